// File: rtl/exec_unit.sv
// exec_unit: 19-bit execute stage with a single-cycle ALU and, when EXEC_MUL_EN
// is defined, an iterative shift-add multiplier that stalls issue while it runs.
module exec_unit #(
  parameter int DATA_W     = 19,
  parameter int MUL_CYCLES = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  // Handshake: an op is taken on a rising edge where issue_valid_i && issue_ready_o;
  // issue_ready_o depends only on state, never on issue_valid_i.
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [2:0]        rd_addr_i,
  output logic [2:0]        rd_addr_o,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              illegal_o,
  output logic              dbg_state_o
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hA;
`endif

  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  logic              wr_en_q, wr_en_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [2:0]        rd_addr_q, rd_addr_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic [DATA_W:0]   sum_w, diff_w, inc_w, dec_w, shl_w, shr_w;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_legal;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    shamt     = rs2_data_i[4:0];
    sum_w     = {1'b0, rs1_data_i} + {1'b0, rs2_data_i};
    diff_w    = {1'b0, rs1_data_i} - {1'b0, rs2_data_i};
    inc_w     = {1'b0, rs1_data_i} + (DATA_W+1)'(1);
    dec_w     = {1'b0, rs1_data_i} - (DATA_W+1)'(1);
    shl_w     = {1'b0, rs1_data_i} << shamt;
    shr_w     = {rs1_data_i, 1'b0} >> shamt;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_legal = 1'b1;
    case (op_i)
      OP_ADD: begin alu_res = sum_w[DATA_W-1:0];  alu_carry = sum_w[DATA_W];  end
      OP_SUB: begin alu_res = diff_w[DATA_W-1:0]; alu_carry = diff_w[DATA_W]; end
      OP_AND: alu_res = rs1_data_i & rs2_data_i;
      OP_OR:  alu_res = rs1_data_i | rs2_data_i;
      OP_XOR: alu_res = rs1_data_i ^ rs2_data_i;
      OP_NOT: alu_res = ~rs1_data_i;
      OP_INC: begin alu_res = inc_w[DATA_W-1:0];  alu_carry = inc_w[DATA_W];  end
      OP_DEC: begin alu_res = dec_w[DATA_W-1:0];  alu_carry = dec_w[DATA_W];  end
      OP_SHL: begin alu_res = shl_w[DATA_W-1:0];  alu_carry = shl_w[DATA_W];  end
      OP_SHR: begin alu_res = shr_w[DATA_W:1];    alu_carry = shr_w[0];       end
      default: alu_legal = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [4:0]          count_q, count_d;
  logic [2:0]          mul_rd_q, mul_rd_d;
  logic [2*DATA_W-1:0] mul_add;

  assign issue_ready_o = (state_q == IDLE);
  assign dbg_state_o   = state_q;
`else
  assign issue_ready_o = 1'b1;
  assign dbg_state_o   = IDLE;
`endif

  always_comb begin
    wr_en_d   = 1'b0;
    illegal_d = 1'b0;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
`ifdef EXEC_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    mul_rd_d = mul_rd_q;
    mul_add  = '0;
    if (state_q == MUL_RUN) begin
      if (mplier_q[count_q]) mul_add = {{DATA_W{1'b0}}, mcand_q} << count_q;
      acc_d   = acc_q + mul_add;
      count_d = count_q + 5'd1;
      if (count_q == 5'(MUL_CYCLES-1)) begin
        state_d   = IDLE;
        count_d   = '0;
        wr_en_d   = (mul_rd_q != 3'd0);
        wr_data_d = acc_d[DATA_W-1:0];
        rd_addr_d = mul_rd_q;
        zero_d    = (acc_d[DATA_W-1:0] == '0);
        carry_d   = |acc_d[2*DATA_W-1:DATA_W];
      end
    end else if (issue_valid_i && op_i == OP_MUL) begin
      state_d  = MUL_RUN;
      mcand_d  = rs1_data_i;
      mplier_d = rs2_data_i;
      acc_d    = '0;
      count_d  = '0;
      mul_rd_d = rd_addr_i;
    end else
`endif
    if (issue_valid_i) begin
      if (alu_legal) begin
        wr_en_d   = (rd_addr_i != 3'd0);
        wr_data_d = alu_res;
        rd_addr_d = rd_addr_i;
        zero_d    = (alu_res == '0);
        carry_d   = alu_carry;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
`ifdef EXEC_MUL_EN
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      mul_rd_q  <= '0;
`endif
    end else begin
      wr_en_q   <= wr_en_d;
      illegal_q <= illegal_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
`ifdef EXEC_MUL_EN
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      mul_rd_q  <= mul_rd_d;
`endif
    end
  end

  assign wr_en_o   = wr_en_q;
  assign illegal_o = illegal_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = rd_addr_q;
  assign zero_o    = zero_q;
  assign carry_o   = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit: ALU vector stream, illegal/rd=0 handling,
// multiply (or its absence without EXEC_MUL_EN) and reset during operation.
module tb_exec_unit;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4, OP_NOT = 4'h5, OP_INC = 4'h6, OP_DEC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_MUL = 4'hA, OP_ILL = 4'hC;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [3:0]  op_i = '0;
  logic [18:0] rs1_data_i = '0;
  logic [18:0] rs2_data_i = '0;
  logic [2:0]  rd_addr_i = '0;
  logic [2:0]  rd_addr_o;
  logic        wr_en_o;
  logic [18:0] wr_data_o;
  logic        zero_o, carry_o, illegal_o, dbg_state_o;

  exec_unit dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .op_i(op_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rd_addr_i(rd_addr_i), .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o),
    .wr_data_o(wr_data_o), .zero_o(zero_o), .carry_o(carry_o),
    .illegal_o(illegal_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] op, input logic [18:0] a, input logic [18:0] b,
                       input logic [2:0] rd, input bit expect_wr, input logic [18:0] exp_data);
    op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; issue_valid_i = 1'b1;
    if (expect_wr && rd != 3'd0) exp_q.push_back({rd, exp_data});
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
  endtask

  // scoreboard: every write-back must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n && wr_en_o) begin
      if (exp_q.size() == 0) chk("unexpected_wr", 32'(wr_en_o), 32'd0);
      else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rd_addr_o), 32'(e[21:19]));
        chk("wr_data", 32'(wr_data_o), 32'(e[18:0]));
      end
    end
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [18:0] a;
    logic [18:0] b;
    logic [2:0]  rd;
    logic [18:0] res;
    logic        c;
  } vec_t;
  vec_t vt[NV];

  int low;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_ADD, 19'h7FFFF, 19'h00001, 3'd3, 19'h00000, 1'b1};
    vt[1]  = '{OP_SUB, 19'h00005, 19'h00007, 3'd2, 19'h7FFFE, 1'b1};
    vt[2]  = '{OP_AND, 19'h0F0F0, 19'h0FF00, 3'd4, 19'h0F000, 1'b0};
    vt[3]  = '{OP_ADD, 19'h12345, 19'h11111, 3'd1, 19'h23456, 1'b0};
    vt[4]  = '{OP_OR,  19'h12345, 19'h00F0F, 3'd5, 19'h12F4F, 1'b0};
    vt[5]  = '{OP_XOR, 19'h7FFFF, 19'h55555, 3'd6, 19'h2AAAA, 1'b0};
    vt[6]  = '{OP_NOT, 19'h00000, 19'h7FFFF, 3'd7, 19'h7FFFF, 1'b0};
    vt[7]  = '{OP_INC, 19'h7FFFF, 19'h00000, 3'd1, 19'h00000, 1'b1};
    vt[8]  = '{OP_DEC, 19'h00000, 19'h00000, 3'd2, 19'h7FFFF, 1'b1};
    vt[9]  = '{OP_SHL, 19'h40001, 19'h00001, 3'd3, 19'h00002, 1'b1};
    vt[10] = '{OP_SHR, 19'h00003, 19'h00001, 3'd4, 19'h00001, 1'b1};
    vt[11] = '{OP_SHL, 19'h00001, 19'h00013, 3'd5, 19'h00000, 1'b1};
    vt[12] = '{OP_SHR, 19'h40000, 19'h00013, 3'd6, 19'h00000, 1'b1};
    vt[13] = '{OP_SHL, 19'h12345, 19'h00000, 3'd7, 19'h12345, 1'b0};
    vt[14] = '{OP_SHR, 19'h7FFFF, 19'h00019, 3'd1, 19'h00000, 1'b0};
    vt[15] = '{OP_SHR, 19'h00004, 19'h00021, 3'd2, 19'h00002, 1'b0};
    vt[16] = '{OP_SUB, 19'h00007, 19'h00005, 3'd3, 19'h00002, 1'b0};

    // reset: outputs cleared and ready high while reset is held
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_wr_data", 32'(wr_data_o), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd0);
    chk("rst_carry", 32'(carry_o), 32'd0);
    reset_n = 1'b1;

    // back-to-back ALU stream: one write-back per cycle, ready never drops
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("alu%0d_wr_en", i-1), 32'(wr_en_o), 32'd1);
        chk($sformatf("alu%0d_zero", i-1), 32'(zero_o), 32'(vt[i-1].res == 19'd0));
        chk($sformatf("alu%0d_carry", i-1), 32'(carry_o), 32'(vt[i-1].c));
        chk($sformatf("alu%0d_illegal", i-1), 32'(illegal_o), 32'd0);
        chk($sformatf("alu%0d_ready", i-1), 32'(issue_ready_o), 32'd1);
      end
      if (i < NV) drive(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, 1'b1, vt[i].res);
      else idle();
    end

    // illegal op holds flags/data; rd=0 suppresses write but updates flags
    @(negedge clk);
    drive(OP_ADD, 19'h12345, 19'h11111, 3'd1, 1'b1, 19'h23456);
    @(negedge clk);
    chk("pre_ill_wr_en", 32'(wr_en_o), 32'd1);
    drive(OP_ILL, 19'h00001, 19'h00001, 3'd2, 1'b0, 19'h0);
    @(negedge clk);
    chk("ill_pulse", 32'(illegal_o), 32'd1);
    chk("ill_wr_en", 32'(wr_en_o), 32'd0);
    chk("ill_data_hold", 32'(wr_data_o), 32'h23456);
    chk("ill_carry_hold", 32'(carry_o), 32'd0);
    chk("ill_zero_hold", 32'(zero_o), 32'd0);
    drive(OP_ADD, 19'h7FFFF, 19'h00001, 3'd0, 1'b1, 19'h0);
    @(negedge clk);
    chk("rd0_wr_en", 32'(wr_en_o), 32'd0);
    chk("rd0_illegal", 32'(illegal_o), 32'd0);
    chk("rd0_zero", 32'(zero_o), 32'd1);
    chk("rd0_carry", 32'(carry_o), 32'd1);
    idle();

`ifdef EXEC_MUL_EN
    // ALU immediately followed by MUL; ready low for exactly 19 cycles
    @(negedge clk);
    drive(OP_ADD, 19'h00010, 19'h00020, 3'd2, 1'b1, 19'h00030);
    @(negedge clk);
    chk("b2b_alu_wr_en", 32'(wr_en_o), 32'd1);
    drive(OP_MUL, 19'd300, 19'd1000, 3'd5, 1'b1, 19'h493E0);
    @(negedge clk);
    idle();
    low = 0;
    for (int n = 0; n < 40 && !issue_ready_o; n++) begin low++; @(negedge clk); end
    chk("mul1_ready_low", 32'(low), 32'd19);
    chk("mul1_wr_en", 32'(wr_en_o), 32'd1);
    chk("mul1_carry", 32'(carry_o), 32'd0);
    chk("mul1_zero", 32'(zero_o), 32'd0);

    drive(OP_MUL, 19'h7FFFF, 19'h00002, 3'd6, 1'b1, 19'h7FFFE);
    @(negedge clk);
    idle();
    low = 0;
    for (int n = 0; n < 40 && !issue_ready_o; n++) begin low++; @(negedge clk); end
    chk("mul2_ready_low", 32'(low), 32'd19);
    chk("mul2_wr_en", 32'(wr_en_o), 32'd1);
    chk("mul2_carry", 32'(carry_o), 32'd1);

    // reset in the middle of a multiply: no write-back for it
    @(negedge clk);
    drive(OP_MUL, 19'd7, 19'd9, 3'd3, 1'b0, 19'h0);
    @(negedge clk);
    idle();
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", 32'(issue_ready_o), 32'd0);
`else
    // without the multiplier opcode A is illegal and never stalls
    @(negedge clk);
    drive(OP_MUL, 19'd300, 19'd1000, 3'd5, 1'b0, 19'h0);
    @(negedge clk);
    chk("nomul_illegal", 32'(illegal_o), 32'd1);
    chk("nomul_wr_en", 32'(wr_en_o), 32'd0);
    chk("nomul_ready", 32'(issue_ready_o), 32'd1);
    idle();
    @(negedge clk);
    chk("nomul_ready2", 32'(issue_ready_o), 32'd1);
    chk("nomul_ill_clr", 32'(illegal_o), 32'd0);
    drive(OP_ADD, 19'h00005, 19'h00000, 3'd6, 1'b1, 19'h00005);
    @(negedge clk);
    idle();
    @(negedge clk);
`endif
    #1 reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(issue_ready_o), 32'd1);
    chk("arst_wr_en", 32'(wr_en_o), 32'd0);
    chk("arst_illegal", 32'(illegal_o), 32'd0);
    chk("arst_wr_data", 32'(wr_data_o), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("arst_zero", 32'(zero_o), 32'd0);
    chk("arst_carry", 32'(carry_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_ready", 32'(issue_ready_o), 32'd1);

    drive(OP_ADD, 19'd1, 19'd1, 3'd1, 1'b1, 19'd2);
    @(negedge clk);
    idle();
    chk("post_rst_add_wr_en", 32'(wr_en_o), 32'd1);
    chk("post_rst_add_data", 32'(wr_data_o), 32'd2);
    @(negedge clk);
    chk("wr_en_one_cycle", 32'(wr_en_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
